instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded at reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port: start  in  1  begin execution from current PC; sampled only in IDLE.
REQ-005 SHALL have port: imem_en  out  1  instruction read strobe.
REQ-006 SHALL have port: imem_addr  out  16  instruction address, equal to PC.
REQ-007 SHALL have port: imem_rdata  in  32  instruction word, valid the cycle after imem_en.
REQ-008 SHALL have port: rf_raddr1  out  5  register index for instr[25:21].
REQ-009 SHALL have port: rf_raddr2  out  5  register index for instr[20:16].
REQ-010 SHALL have port: rf_rdata1  in  32  combinational read data for rf_raddr1, used by jr.
REQ-011 SHALL have port: rf_we  out  1  register write strobe, one cycle.
REQ-012 SHALL have port: rf_waddr  out  5  register write index.
REQ-013 SHALL have port: rf_wdata  out  32  register write data.
REQ-014 SHALL have port: alu_opcode  out  6  to ALU, instr[31:26].
REQ-015 SHALL have port: alu_funct  out  5  to ALU, instr[4:0].
REQ-016 SHALL have port: alu_shamt  out  5  to ALU, instr[10:6].
REQ-017 SHALL have port: alu_const  out  16  to ALU, instr[15:0].
REQ-018 SHALL have port: alu_jaddr  out  26  to ALU, instr[25:0].
REQ-019 SHALL have port: alu_pc  out  16  to ALU, PC+1 (mod 2^16).
REQ-020 SHALL have port: alu_dest  in  32  ALU result.
REQ-021 SHALL have port: alu_pc_new  in  16  ALU branch/jump target.
REQ-022 SHALL have port: busy  out  1  high in every state except IDLE and HALT.
REQ-023 SHALL have port: halted  out  1  high in HALT.
REQ-024 SHALL have port: illegal  out  1  high in HALT when entered via an illegal instruction.

Function
REQ-025 SHALL implement FSM IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH, plus HALT; 4 cycles per instruction.
REQ-026 IDLE: start=1 -> FETCH; start is ignored in all other states.
REQ-027 FETCH: imem_en=1, imem_addr=PC; DECODE: capture imem_rdata into IR, drive rf_raddr1/2 from IR.
REQ-028 alu_* outputs SHALL be driven from IR from DECODE through WB and held until the next DECODE; ALU s1/s2 are wired at top level to rf_rdata1/rf_rdata2.
REQ-029 EXEC: capture alu_dest and alu_pc_new into internal registers; decode class; illegal or halt -> HALT, else -> WB.
REQ-030 Opcode 0, funct 0-8: write rd=instr[15:11] with alu_dest; funct 9-31 is illegal.
REQ-031 Opcodes 1-4: write instr[25:21] with alu_dest; opcode 16: write instr[20:16] with alu_dest.
REQ-032 Opcodes 7-12: no write; PC <= captured alu_pc_new (ALU returns target or PC+1).
REQ-033 Opcode 13: PC <= alu_pc_new; opcode 14: PC <= rf_rdata1[15:0]; opcode 15: write r31 with {16'd0, PC+1}, PC <= alu_pc_new.
REQ-034 alu_pc_new SHALL be used only for opcodes 7-13 and 15 (ALU leaves it unassigned otherwise).
REQ-035 All other instructions: PC <= PC+1 in WB, wrapping 16'hFFFF -> 16'h0000.
REQ-036 Opcode 63: HALT, illegal=0; opcodes 5, 6, 17-62: HALT, illegal=1; no rf_we, PC unchanged.
REQ-037 rf_we SHALL pulse only in WB and SHALL be suppressed when rf_waddr=0.
REQ-038 HALT SHALL be exited only by reset.

Reset
REQ-039 rst_n=0 at a clock edge SHALL force IDLE, PC=RESET_PC, IR=0, all outputs 0, from any state including mid-instruction; an abandoned instruction SHALL produce no rf_we.

Verification
REQ-040 r1=5, r2=7, imem[0]=add rs=1 rt=2 rd=3 funct=0, start -> WB in cycle 4: rf_we=1, waddr=3, wdata=12; next imem_addr=1.
REQ-041 beq (op 7) r1=r2, const=0x0040 -> next fetch 0x0040; with r1!=r2 -> next fetch PC+1.
REQ-042 jal (op 15) at PC=5, jaddr=0x0100 -> rf write r31=6; next fetch 0x0100.
REQ-043 opcode 5 -> halted=1, illegal=1, busy=0, no rf_we; later start pulses ignored.
REQ-044 rst_n=0 during EXEC -> next cycle busy=0, imem_addr=RESET_PC, rf_we never asserted.
REQ-045 add at PC=0xFFFF -> next fetch 0x0000; addi writing r0 -> rf_we stays 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle instruction sequencer. It fetches a 32-bit instruction word from
// instruction memory, presents the decoded fields to an external ALU and
// register file, captures the ALU results, and then performs register
// writeback and updates the PC. Each instruction takes four cycles:
// FETCH, DECODE, EXEC and WB. Halt and illegal opcodes park the machine in
// HALT, which only reset can leave.
//
// Ports
//   clk         in   1   clock; all state updates on the rising edge
//   rst_n       in   1   synchronous active-low reset
//   start       in   1   begin execution from the current PC (IDLE only)
//   imem_en     out  1   instruction read strobe (high in FETCH)
//   imem_addr   out  16  instruction address (= PC)
//   imem_rdata  in   32  instruction word, valid the cycle after imem_en
//   rf_raddr1   out  5   register read index, instr[25:21]
//   rf_raddr2   out  5   register read index, instr[20:16]
//   rf_rdata1   in   32  combinational read data for rf_raddr1 (jr target)
//   rf_we       out  1   register write strobe, one cycle in WB
//   rf_waddr    out  5   register write index
//   rf_wdata    out  32  register write data
//   alu_opcode  out  6   instr[31:26]
//   alu_funct   out  5   instr[4:0]
//   alu_shamt   out  5   instr[10:6]
//   alu_const   out  16  instr[15:0]
//   alu_jaddr   out  26  instr[25:0]
//   alu_pc      out  16  PC+1 (mod 2^16)
//   alu_dest    in   32  ALU result
//   alu_pc_new  in   16  ALU branch/jump target
//   busy        out  1   high in FETCH, DECODE, EXEC and WB
//   halted      out  1   high in HALT
//   illegal     out  1   high in HALT when entered via an illegal instruction
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [5:0]  alu_opcode,
    output logic [4:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    output logic [15:0] alu_const,
    output logic [25:0] alu_jaddr,
    output logic [15:0] alu_pc,
    input  logic [31:0] alu_dest,
    input  logic [15:0] alu_pc_new,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_pc_next;
    logic [31:0] r_ir;
    logic [15:0] r_alu_pc;
    logic        r_imem_en;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_busy;
    logic        r_halted;
    logic        r_illegal;

    // Execute-stage decode results, consumed on the EXEC -> WB/HALT edge.
    logic [5:0]  w_op;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [15:0] w_pc_next;
    logic        w_halt;
    logic        w_illegal;

    // Only the low half of rf_rdata1 forms a jr target.
    logic        w_unused_rdata1_hi;
    assign w_unused_rdata1_hi = &{1'b0, rf_rdata1[31:16]};

    assign w_op = r_ir[31:26];

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = alu_dest;
        w_pc_next = r_pc + 16'd1;
        w_halt    = 1'b0;
        w_illegal = 1'b0;
        if (w_op == 6'd0) begin
            if (r_ir[4:0] <= 5'd8) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_ir[15:11];
            end else begin
                w_halt    = 1'b1;
                w_illegal = 1'b1;
            end
        end else if (w_op >= 6'd1 && w_op <= 6'd4) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ir[25:21];
        end else if (w_op == 6'd16) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ir[20:16];
        end else if (w_op >= 6'd7 && w_op <= 6'd13) begin
            // Conditional branches: the ALU returns either the target or PC+1.
            w_pc_next = alu_pc_new;
        end else if (w_op == 6'd14) begin
            w_pc_next = rf_rdata1[15:0];
        end else if (w_op == 6'd15) begin
            w_wr_en   = 1'b1;
            w_wr_addr = 5'd31;
            w_wr_data = {16'd0, r_alu_pc};
            w_pc_next = alu_pc_new;
        end else if (w_op == 6'd63) begin
            w_halt = 1'b1;
        end else begin
            w_halt    = 1'b1;
            w_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_next  <= RESET_PC;
            r_ir       <= '0;
            r_alu_pc   <= '0;
            r_imem_en  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_imem_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state   <= S_DECODE;
                    r_imem_en <= 1'b0;
                end
                S_DECODE: begin
                    r_state  <= S_EXEC;
                    r_ir     <= imem_rdata;
                    r_alu_pc <= r_pc + 16'd1;
                end
                S_EXEC: begin
                    if (w_halt) begin
                        r_state   <= S_HALT;
                        r_busy    <= 1'b0;
                        r_halted  <= 1'b1;
                        r_illegal <= w_illegal;
                    end else begin
                        r_state    <= S_WB;
                        // r0 is hardwired: never strobe a write to it.
                        r_rf_we    <= w_wr_en && (w_wr_addr != 5'd0);
                        r_rf_waddr <= w_wr_addr;
                        r_rf_wdata <= w_wr_data;
                        r_pc_next  <= w_pc_next;
                    end
                end
                S_WB: begin
                    r_state   <= S_FETCH;
                    r_rf_we   <= 1'b0;
                    r_pc      <= r_pc_next;
                    r_imem_en <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_en    = r_imem_en;
    assign imem_addr  = r_pc;
    assign rf_raddr1  = r_ir[25:21];
    assign rf_raddr2  = r_ir[20:16];
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign alu_opcode = r_ir[31:26];
    assign alu_funct  = r_ir[4:0];
    assign alu_shamt  = r_ir[10:6];
    assign alu_const  = r_ir[15:0];
    assign alu_jaddr  = r_ir[25:0];
    assign alu_pc     = r_alu_pc;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  alu_opcode;
    logic [4:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic [15:0] alu_const;
    logic [25:0] alu_jaddr;
    logic [15:0] alu_pc;
    logic [31:0] alu_dest;
    logic [15:0] alu_pc_new;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [31:0] imem [0:65535];
    logic [31:0] regs [0:31];
    logic [31:0] s2;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    instr_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_opcode (alu_opcode),
        .alu_funct  (alu_funct),
        .alu_shamt  (alu_shamt),
        .alu_const  (alu_const),
        .alu_jaddr  (alu_jaddr),
        .alu_pc     (alu_pc),
        .alu_dest   (alu_dest),
        .alu_pc_new (alu_pc_new),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    always @(posedge clk) begin
        if (rf_we === 1'b1) we_count++;
    end

    // Environment ALU: op 0 adds registers, op 7 is beq, 13/15 jump to
    // jaddr[15:0]; other ops add the immediate. alu_pc_new is 16'hDEAD when
    // the sequencer must not use it.
    always_comb begin
        rf_rdata1 = regs[rf_raddr1];
        s2        = regs[rf_raddr2];
        if (alu_opcode == 6'd0) alu_dest = rf_rdata1 + s2;
        else                    alu_dest = rf_rdata1 + {16'd0, alu_const};
        case (alu_opcode)
            6'd7:         alu_pc_new = (rf_rdata1 == s2) ? alu_const : alu_pc;
            6'd13, 6'd15: alu_pc_new = alu_jaddr[15:0];
            default:      alu_pc_new = 16'hDEAD;
        endcase
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [4:0] fn);
        return {6'd0, rs, rt, rd, sh, 1'b0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] ja);
        return {op, ja};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse start in IDLE; returns with the DUT in FETCH of the first instruction.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL reset_imem_en: got %b want 0", imem_en); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_imem_addr: got %h want 0000", imem_addr); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        checks++; if (alu_jaddr !== 26'd0 || alu_opcode !== 6'd0) begin failures++; $display("FAIL reset_ir: got op=%h ja=%h want 0", alu_opcode, alu_jaddr); end
        checks++; if (alu_pc !== 16'h0000) begin failures++; $display("FAIL reset_alu_pc: got %h want 0000", alu_pc); end
    endtask

    task automatic test_add();
        do_reset();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        imem[0] = enc_r(5'd1, 5'd2, 5'd3, 5'd3, 5'd0);
        kick();
        checks++; if (imem_en !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL add_fetch: got en=%b addr=%h want en=1 addr=0000", imem_en, imem_addr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy: got %b want 1", busy); end
        tick();
        tick();
        checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin failures++; $display("FAIL add_raddr: got %0d,%0d want 1,2", rf_raddr1, rf_raddr2); end
        checks++; if (alu_shamt !== 5'd3 || alu_funct !== 5'd0 || alu_pc !== 16'h0001) begin failures++; $display("FAIL add_alu_fields: got sh=%0d fn=%0d pc=%h want 3,0,0001", alu_shamt, alu_funct, alu_pc); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'd12) begin failures++; $display("FAIL add_wb: got we=%b wa=%0d wd=%0d want 1,3,12", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (imem_addr !== 16'h0001 || imem_en !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL add_next_fetch: got addr=%h en=%b we=%b want 0001,1,0", imem_addr, imem_en, rf_we); end
    endtask

    task automatic test_branch();
        int w0;
        do_reset();
        regs[1] = 32'd9;
        regs[2] = 32'd9;
        regs[3] = 32'd1;
        imem[0]     = enc_i(6'd7, 5'd1, 5'd2, 16'h0040);
        imem[16'h40] = enc_i(6'd7, 5'd1, 5'd3, 16'h0080);
        w0 = we_count;
        kick();
        repeat (4) tick();
        checks++; if (imem_addr !== 16'h0040) begin failures++; $display("FAIL beq_taken: got %h want 0040", imem_addr); end
        repeat (4) tick();
        checks++; if (imem_addr !== 16'h0041) begin failures++; $display("FAIL beq_not_taken: got %h want 0041", imem_addr); end
        checks++; if (we_count !== w0) begin failures++; $display("FAIL beq_no_write: got %0d writes want 0", we_count - w0); end
    endtask

    task automatic test_jal_jr();
        do_reset();
        regs[4]      = 32'hABCD_1234;
        imem[0]      = enc_j(6'd13, 26'h0000005);
        imem[5]      = enc_j(6'd15, 26'h0000100);
        imem[16'h100] = enc_i(6'd14, 5'd4, 5'd0, 16'h0000);
        kick();
        repeat (4) tick();
        checks++; if (imem_addr !== 16'h0005) begin failures++; $display("FAIL jump_target: got %h want 0005", imem_addr); end
        repeat (3) tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'd6) begin failures++; $display("FAIL jal_link: got we=%b wa=%0d wd=%h want 1,31,00000006", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL jal_target: got %h want 0100", imem_addr); end
        repeat (4) tick();
        checks++; if (imem_addr !== 16'h1234) begin failures++; $display("FAIL jr_target: got %h want 1234", imem_addr); end
    endtask

    task automatic test_halt();
        do_reset();
        imem[0] = enc_j(6'd63, 26'd0);
        kick();
        repeat (3) tick();
        checks++; if (halted !== 1'b1 || illegal !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL halt_op63: got h=%b i=%b b=%b want 1,0,0", halted, illegal, busy); end
    endtask

    task automatic test_illegal();
        int w0;
        do_reset();
        imem[0] = enc_j(6'd5, 26'd0);
        w0 = we_count;
        kick();
        repeat (3) tick();
        checks++; if (halted !== 1'b1 || illegal !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL illegal_op5: got h=%b i=%b b=%b want 1,1,0", halted, illegal, busy); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL illegal_pc_held: got %h want 0000", imem_addr); end
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
        checks++; if (halted !== 1'b1 || busy !== 1'b0 || imem_en !== 1'b0) begin failures++; $display("FAIL halt_ignores_start: got h=%b b=%b en=%b want 1,0,0", halted, busy, imem_en); end
        checks++; if (we_count !== w0) begin failures++; $display("FAIL illegal_no_write: got %0d writes want 0", we_count - w0); end
        do_reset();
        checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_exits_halt: got h=%b i=%b want 0,0", halted, illegal); end
        imem[0] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 5'd9);
        kick();
        repeat (3) tick();
        checks++; if (halted !== 1'b1 || illegal !== 1'b1 || we_count !== w0) begin failures++; $display("FAIL illegal_funct9: got h=%b i=%b writes=%0d want 1,1,0", halted, illegal, we_count - w0); end
    endtask

    task automatic test_reset_mid();
        int w0;
        do_reset();
        regs[1] = 32'd2;
        imem[0] = enc_i(6'd1, 5'd1, 5'd0, 16'h0010);
        w0 = we_count;
        kick();
        tick();
        tick();
        checks++; if (alu_opcode !== 6'd1) begin failures++; $display("FAIL midreset_in_exec: got op=%0d want 1", alu_opcode); end
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || imem_addr !== 16'h0000 || rf_we !== 1'b0) begin failures++; $display("FAIL midreset_state: got b=%b addr=%h we=%b want 0,0000,0", busy, imem_addr, rf_we); end
        checks++; if (alu_opcode !== 6'd0 || imem_en !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got op=%0d en=%b want 0,0", alu_opcode, imem_en); end
        rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (we_count !== w0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_no_write: got writes=%0d b=%b want 0,0", we_count - w0, busy); end
    endtask

    task automatic test_wrap_r0();
        int w0;
        do_reset();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        imem[0]        = enc_j(6'd13, 26'h000FFFF);
        imem[16'hFFFF] = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 5'd8);
        kick();
        repeat (4) tick();
        checks++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_reach: got %h want ffff", imem_addr); end
        tick();
        tick();
        checks++; if (alu_pc !== 16'h0000) begin failures++; $display("FAIL wrap_alu_pc: got %h want 0000", alu_pc); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'd12) begin failures++; $display("FAIL funct8_write: got we=%b wa=%0d wd=%0d want 1,5,12", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_fetch: got %h want 0000", imem_addr); end
        do_reset();
        imem[0] = enc_i(6'd1, 5'd0, 5'd0, 16'h0007);
        w0 = we_count;
        kick();
        repeat (3) tick();
        checks++; if (rf_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL r0_suppress: got we=%b b=%b want 0,1", rf_we, busy); end
        tick();
        checks++; if (imem_addr !== 16'h0001 || we_count !== w0) begin failures++; $display("FAIL r0_next: got addr=%h writes=%0d want 0001,0", imem_addr, we_count - w0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        imem[0] = enc_i(6'd16, 5'd1, 5'd6, 16'h0003);
        imem[1] = enc_i(6'd2, 5'd2, 5'd0, 16'h0010);
        kick();
        repeat (3) tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'd8) begin failures++; $display("FAIL op16_write: got we=%b wa=%0d wd=%0d want 1,6,8", rf_we, rf_waddr, rf_wdata); end
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'd23) begin failures++; $display("FAIL op2_write: got we=%b wa=%0d wd=%0d want 1,2,23", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (imem_addr !== 16'h0002 || busy !== 1'b1) begin failures++; $display("FAIL b2b_next: got addr=%h b=%b want 0002,1", imem_addr, busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 65536; i++) imem[i] = 32'hFC00_0000;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        tick();
        test_reset();
        test_add();
        test_branch();
        test_jal_jr();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_wrap_r0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
